// File: rtl/sram_like_data_responder.sv
// Responder end of the SRAM-like data interface. Acts as the on-chip data
// memory: requests are accepted into an in-order queue, stores are applied at
// acceptance, loads capture their word at acceptance, and every accepted
// request completes with one data_ok pulse after a programmable latency.
module sram_like_data_responder #(
  parameter int ADDR_WIDTH = 10,  // word-index bits
  parameter int LATENCY    = 2,   // accept-to-data_ok cycles, 1..7
  parameter int DEPTH      = 2    // outstanding requests, power of two, 2..8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        addr_stall,
  input  logic        resp_stall,
  output logic        err,
  output logic [3:0]  outstanding
);

  localparam int         PTR_W     = $clog2(DEPTH);
  localparam int         WORDS     = 1 << ADDR_WIDTH;
  localparam logic [2:0] LAT       = 3'(LATENCY);
  localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [31:0] data;
    logic [2:0]  age;
  } entry_t;

  logic [31:0]           mem [WORDS];
  entry_t                queue [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [3:0]            count;
  logic                  full;
  logic                  accept;
  logic                  misaligned;
  logic [ADDR_WIDTH-1:0] word_idx;
  entry_t                head_entry;
  logic                  addr_unused;

  // Upper address bits are deliberately ignored so the memory aliases.
  assign addr_unused = ^addr[31:ADDR_WIDTH+2];

  assign word_idx   = addr[ADDR_WIDTH+1:2];
  assign full       = (count == DEPTH_CNT);
  assign addr_ok    = req && !full && !addr_stall && !reset;
  assign accept     = addr_ok;
  assign head_entry = queue[head];
  assign outstanding = count;

  // Completion: only the head may complete, and only once it has aged enough.
  assign data_ok = head_entry.valid && (head_entry.age >= LAT) && !resp_stall && !reset;
  assign rdata   = (data_ok && !head_entry.wr) ? head_entry.data : 32'h0;

  // Flag accesses that are misaligned for their size, or use the illegal size.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    misaligned = 1'b0;
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Apply accepted, well-formed stores byte by byte under wstrb.
  // NOTE: the memory array has no reset; accepted stores survive a reset.
  always_ff @(posedge clk) begin
    if (accept && wr && !misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Queue bookkeeping: aging, pop at completion, push at acceptance, error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) queue[i].valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; a later write to the same entry in this
      // block (push after age/pop) takes precedence at the edge.
      for (int i = 0; i < DEPTH; i++) begin
        if (queue[i].valid && (queue[i].age < LAT)) queue[i].age <= queue[i].age + 3'd1;
      end
      if (data_ok) begin
        queue[head].valid <= 1'b0;
        head              <= head + 1'b1;
      end
      if (accept) begin
        // The load word is sampled now, so it reflects every earlier store.
        queue[tail] <= '{valid: 1'b1,
                         wr:    wr,
                         data:  (!wr && !misaligned) ? mem[word_idx] : 32'h0,
                         age:   3'd1};
        tail <= tail + 1'b1;
        if (misaligned) err <= 1'b1;
      end
      case ({accept, data_ok})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_data_responder.sv
// Directed bench for sram_like_data_responder: latency, byte strobes,
// backpressure, misalignment, reset with requests in flight, aliasing and
// pointer wrap on a LATENCY=1 instance.
module tb_sram_like_data_responder;

  logic        clk;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_stall, resp_stall;
  logic        addr_ok, data_ok, err;
  logic [31:0] rdata;
  logic [3:0]  outstanding;

  logic        f_req, f_wr;
  logic [1:0]  f_size;
  logic [3:0]  f_wstrb;
  logic [31:0] f_addr, f_wdata;
  logic        f_addr_stall, f_resp_stall;
  logic        f_addr_ok, f_data_ok, f_err;
  logic [31:0] f_rdata;
  logic [3:0]  f_outstanding;

  int total = 0;
  int bad   = 0;

  sram_like_data_responder #(.ADDR_WIDTH(10), .LATENCY(2), .DEPTH(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .addr_stall(addr_stall), .resp_stall(resp_stall),
    .err(err), .outstanding(outstanding)
  );

  sram_like_data_responder #(.ADDR_WIDTH(10), .LATENCY(1), .DEPTH(2)) u_dut_fast (
    .clk(clk), .reset(reset), .req(f_req), .wr(f_wr), .size(f_size), .wstrb(f_wstrb),
    .addr(f_addr), .wdata(f_wdata), .addr_ok(f_addr_ok), .data_ok(f_data_ok),
    .rdata(f_rdata), .addr_stall(f_addr_stall), .resp_stall(f_resp_stall),
    .err(f_err), .outstanding(f_outstanding)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] s, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; wr = w; size = s; wstrb = st; addr = a; wdata = d;
  endtask

  task automatic idle();
    req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    drive(1'b0, 2'd2, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    total++; if (addr_ok !== 1'b0) begin bad++; $display("FAIL rst_addr_ok: got %0b want 0", addr_ok); end
    next_cycle();
    reset = 1'b0;
    idle();
    @(negedge clk);
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", err); end
    total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL rst_data_ok: got %0b want 0", data_ok); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    next_cycle();
  endtask

  task automatic test_latency();
    drive(1'b1, 2'd2, 4'hF, 32'h100, 32'h11223344);
    @(negedge clk);
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL lat_st_addr_ok: got %0b want 1", addr_ok); end
    next_cycle();
    drive(1'b0, 2'd2, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL lat_ld_addr_ok: got %0b want 1", addr_ok); end
    total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL lat_early: got %0b want 0", data_ok); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL lat_st_done: got %0b want 1", data_ok); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL lat_st_rdata: got %h want 0", rdata); end
    next_cycle();
    @(negedge clk);
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL lat_ld_done: got %0b want 1", data_ok); end
    total++; if (rdata !== 32'h11223344) begin bad++; $display("FAIL lat_ld_rdata: got %h want 11223344", rdata); end
    next_cycle();
    @(negedge clk);
    total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL lat_quiet: got %0b want 0", data_ok); end
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL lat_empty: got %0d want 0", outstanding); end
    next_cycle();
  endtask

  task automatic test_strobes();
    drive(1'b1, 2'd0, 4'b0010, 32'h101, 32'hAAAAAAAA);
    next_cycle();
    drive(1'b0, 2'd2, 4'h0, 32'h100, 32'h0);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL strb_done: got %0b want 1", data_ok); end
    total++; if (rdata !== 32'h1122AA44) begin bad++; $display("FAIL strb_rdata: got %h want 1122aa44", rdata); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL strb_err: got %0b want 0", err); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    resp_stall = 1'b1;
    drive(1'b0, 2'd2, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL bp_acc0: got %0b want 1", addr_ok); end
    next_cycle();
    @(negedge clk);
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL bp_acc1: got %0b want 1", addr_ok); end
    next_cycle();
    @(negedge clk);
    total++; if (addr_ok !== 1'b0) begin bad++; $display("FAIL bp_full_addr_ok: got %0b want 0", addr_ok); end
    total++; if (outstanding !== 4'd2) begin bad++; $display("FAIL bp_full_cnt: got %0d want 2", outstanding); end
    total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL bp_stalled: got %0b want 0", data_ok); end
    next_cycle();
    resp_stall = 1'b0;
    @(negedge clk);
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL bp_pop0: got %0b want 1", data_ok); end
    total++; if (rdata !== 32'h1122AA44) begin bad++; $display("FAIL bp_pop0_rdata: got %h want 1122aa44", rdata); end
    total++; if (addr_ok !== 1'b0) begin bad++; $display("FAIL bp_pop_no_free: got %0b want 0", addr_ok); end
    next_cycle();
    @(negedge clk);
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL bp_pop1: got %0b want 1", data_ok); end
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL bp_acc2: got %0b want 1", addr_ok); end
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL bp_gap: got %0b want 0", data_ok); end
    next_cycle();
    @(negedge clk);
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL bp_pop2: got %0b want 1", data_ok); end
    total++; if (rdata !== 32'h1122AA44) begin bad++; $display("FAIL bp_pop2_rdata: got %h want 1122aa44", rdata); end
    next_cycle();
    @(negedge clk);
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL bp_empty: got %0d want 0", outstanding); end
    next_cycle();
  endtask

  task automatic test_misalign();
    drive(1'b0, 2'd2, 4'h0, 32'h102, 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL mis_err_set: got %0b want 1", err); end
    total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL mis_early: got %0b want 0", data_ok); end
    next_cycle();
    @(negedge clk);
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL mis_done: got %0b want 1", data_ok); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL mis_rdata: got %h want 0", rdata); end
    next_cycle();
    drive(1'b1, 2'd1, 4'b1000, 32'h103, 32'hFFFFFFFF);
    next_cycle();
    drive(1'b0, 2'd2, 4'h0, 32'h100, 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL mis_st_done: got %0b want 1", data_ok); end
    next_cycle();
    @(negedge clk);
    total++; if (rdata !== 32'h1122AA44) begin bad++; $display("FAIL mis_mem_kept: got %h want 1122aa44", rdata); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL mis_err_sticky: got %0b want 1", err); end
    next_cycle();
  endtask

  task automatic test_reset_outstanding();
    drive(1'b1, 2'd2, 4'hF, 32'h200, 32'hCAFEF00D);
    next_cycle();
    drive(1'b0, 2'd2, 4'h0, 32'h100, 32'h0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    total++; if (outstanding !== 4'd2) begin bad++; $display("FAIL rso_pending: got %0d want 2", outstanding); end
    total++; if (addr_ok !== 1'b0) begin bad++; $display("FAIL rso_addr_ok: got %0b want 0", addr_ok); end
    next_cycle();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL rso_discard[%0d]: got %0b want 0", i, data_ok); end
      next_cycle();
    end
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL rso_cnt: got %0d want 0", outstanding); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rso_err: got %0b want 0", err); end
    drive(1'b0, 2'd2, 4'h0, 32'h200, 32'h0);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL rso_ld_done: got %0b want 1", data_ok); end
    total++; if (rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL rso_mem_kept: got %h want cafef00d", rdata); end
    next_cycle();
  endtask

  task automatic test_alias();
    drive(1'b1, 2'd2, 4'hF, 32'h1000, 32'h5A5A1234);
    next_cycle();
    drive(1'b0, 2'd2, 4'h0, 32'h0000, 32'h0);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL alias_done: got %0b want 1", data_ok); end
    total++; if (rdata !== 32'h5A5A1234) begin bad++; $display("FAIL alias_rdata: got %h want 5a5a1234", rdata); end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    for (int c = 0; c <= 10; c++) begin
      if (c < 5) begin
        f_req = 1'b1; f_wr = 1'b1; f_size = 2'd2; f_wstrb = 4'hF;
        f_addr = 32'h40 + 32'(4 * c); f_wdata = 32'hD0000000 + 32'(c);
      end else if (c < 10) begin
        f_req = 1'b1; f_wr = 1'b0; f_size = 2'd2; f_wstrb = 4'h0;
        f_addr = 32'h40 + 32'(4 * (c - 5)); f_wdata = 32'h0;
      end else begin
        f_req = 1'b0; f_wr = 1'b0; f_wstrb = 4'h0; f_addr = 32'h0;
      end
      @(negedge clk);
      if (c < 10) begin
        total++; if (f_addr_ok !== 1'b1) begin bad++; $display("FAIL wrap_acc[%0d]: got %0b want 1", c, f_addr_ok); end
      end
      if (c >= 1) begin
        exp = (c - 1 < 5) ? 32'h0 : 32'hD0000000 + 32'(c - 6);
        total++; if (f_data_ok !== 1'b1) begin bad++; $display("FAIL wrap_ok[%0d]: got %0b want 1", c - 1, f_data_ok); end
        total++; if (f_rdata !== exp) begin bad++; $display("FAIL wrap_rdata[%0d]: got %h want %h", c - 1, f_rdata, exp); end
      end
      next_cycle();
    end
    @(negedge clk);
    total++; if (f_outstanding !== 4'd0) begin bad++; $display("FAIL wrap_empty: got %0d want 0", f_outstanding); end
    total++; if (f_data_ok !== 1'b0) begin bad++; $display("FAIL wrap_quiet: got %0b want 0", f_data_ok); end
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    addr_stall = 1'b0; resp_stall = 1'b0;
    idle();
    f_req = 1'b0; f_wr = 1'b0; f_size = 2'd2; f_wstrb = 4'h0;
    f_addr = 32'h0; f_wdata = 32'h0; f_addr_stall = 1'b0; f_resp_stall = 1'b0;
    test_reset();
    test_latency();
    test_strobes();
    test_backpressure();
    test_misalign();
    test_reset_outstanding();
    test_alias();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
